// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {StIdle, StFillReq, StFillWait, StWrite} state_t;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  function automatic int unsigned tag_width(input int unsigned sets_log2,
                                            input int unsigned words_log2);
    return ADDR_W - sets_log2 - words_log2 - BYTE_OFF_W;
  endfunction

  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_way_match.sv
// Parallel tag compare across all ways of one set; one-hot hit vector plus encoded way.
module cache_way_match
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned TAG_W = 23,
  localparam int unsigned WAY_W = way_width(WAYS)
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic [WAYS-1:0]       way_valid,
  output logic [WAYS-1:0]       hit_vec,
  output logic                  hit,
  output logic [WAY_W-1:0]      hit_way
);

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      hit_vec[w] = way_valid[w] && (way_tags[w*TAG_W +: TAG_W] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-through / write-allocate cache with NMRU replacement.
// Optional hit/miss counters are enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS_LOG2  = 5,
  parameter int unsigned WORDS_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);

  localparam int unsigned SETS   = 1 << SETS_LOG2;
  localparam int unsigned WORDS  = 1 << WORDS_LOG2;
  localparam int unsigned TAG_W  = tag_width(SETS_LOG2, WORDS_LOG2);
  localparam int unsigned WAY_W  = way_width(WAYS);
  localparam int unsigned IDX_LO = WORDS_LOG2 + 2;

  state_t                state_q, state_d;
  logic [31:0]           req_addr_q, req_addr_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic [3:0]            req_mask_q, req_mask_d;
  logic                  req_write_q, req_write_d;
  logic [WORDS_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [31:0]           merged_q, merged_d;

  logic [31:0]      data_q [SETS][WAYS][WORDS];
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] mru_q   [SETS];

  // In IDLE the live request is looked up; otherwise the latched one.
  logic [31:0]           look_addr;
  logic [TAG_W-1:0]      look_tag;
  logic [SETS_LOG2-1:0]  look_idx;
  logic [WORDS_LOG2-1:0] look_word;

  assign look_addr = (state_q == StIdle) ? i_req_addr : req_addr_q;
  assign look_tag  = look_addr[31 -: TAG_W];
  assign look_idx  = look_addr[IDX_LO +: SETS_LOG2];
  assign look_word = look_addr[2 +: WORDS_LOG2];

  logic [WAYS*TAG_W-1:0] way_tags;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [31:0]           hit_word;

  always_comb begin
    way_tags = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      way_tags[w*TAG_W +: TAG_W] = tag_q[look_idx][w];
    end
  end

  cache_way_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W)
  ) u_way_match (
    .tag       (look_tag),
    .way_tags  (way_tags),
    .way_valid (valid_q[look_idx]),
    .hit_vec   (hit_vec),
    .hit       (hit),
    .hit_way   (hit_way)
  );

  assign hit_word    = data_q[look_idx][hit_way][look_word];
  assign o_res_rdata = hit ? hit_word : '0;

  // Lowest invalid way wins; otherwise the way after the most recently used one.
  logic [WAY_W-1:0] victim;
  always_comb begin
    int nxt;
    nxt    = (int'(mru_q[look_idx]) + 1) % int'(WAYS);
    victim = WAY_W'(nxt);
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[look_idx][w]) victim = WAY_W'(w);
    end
  end

  logic                  data_we, tag_we, mru_we;
  logic [WAY_W-1:0]      data_way, mru_way;
  logic [WORDS_LOG2-1:0] data_word;
  logic [31:0]           data_wval;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_mask_d  = req_mask_q;
    req_write_d = req_write_q;
    fill_cnt_d  = fill_cnt_q;
    victim_d    = victim_q;
    merged_d    = merged_q;
    data_we     = 1'b0;
    data_way    = hit_way;
    data_word   = look_word;
    data_wval   = i_mem_rdata;
    tag_we      = 1'b0;
    mru_we      = 1'b0;
    mru_way     = hit_way;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        o_busy = i_req_wen | (i_req_ren & ~hit);
        if (i_req_wen | i_req_ren) begin
          req_addr_d  = i_req_addr;
          req_wdata_d = i_req_wdata;
          req_mask_d  = i_req_mask;
          req_write_d = i_req_wen;
          if (hit) begin
            mru_we = 1'b1;
            if (i_req_wen) begin
              data_we   = 1'b1;
              data_wval = merge_bytes(hit_word, i_req_wdata, i_req_mask);
              merged_d  = data_wval;
              state_d   = StWrite;
            end
          end else begin
            victim_d   = victim;
            fill_cnt_d = '0;
            state_d    = StFillReq;
          end
        end
      end
      StFillReq: begin
        o_mem_ren  = 1'b1;
        o_mem_addr = {req_addr_q[31:IDX_LO], fill_cnt_q, 2'b00};
        if (i_mem_ready) state_d = StFillWait;
      end
      StFillWait: begin
        if (i_mem_valid) begin
          data_we   = 1'b1;
          data_way  = victim_q;
          data_word = fill_cnt_q;
          // A write-allocate merges the pending store into the word as it arrives.
          if (req_write_q && (fill_cnt_q == look_word)) begin
            data_wval = merge_bytes(i_mem_rdata, req_wdata_q, req_mask_q);
            merged_d  = data_wval;
          end
          if (fill_cnt_q == '1) begin
            tag_we  = 1'b1;
            mru_we  = 1'b1;
            mru_way = victim_q;
            state_d = req_write_q ? StWrite : StIdle;
          end else begin
            fill_cnt_d = fill_cnt_q + WORDS_LOG2'(1);
            state_d    = StFillReq;
          end
        end
      end
      StWrite: begin
        o_mem_wen   = 1'b1;
        o_mem_addr  = {req_addr_q[31:2], 2'b00};
        o_mem_wdata = merged_q;
        if (i_mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!i_rst_n) begin
      o_mem_ren   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_mask_q  <= '0;
      req_write_q <= 1'b0;
      fill_cnt_q  <= '0;
      victim_q    <= '0;
      merged_q    <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_mask_q  <= req_mask_d;
      req_write_q <= req_write_d;
      fill_cnt_q  <= fill_cnt_d;
      victim_q    <= victim_d;
      merged_q    <= merged_d;
      if (tag_we) valid_q[look_idx][victim_q] <= 1'b1;
      if (mru_we) mru_q[look_idx] <= mru_way;
    end
  end

  // Line storage carries no reset; a reset just drops in-flight writes.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && data_we) data_q[look_idx][data_way][data_word] <= data_wval;
    if (i_rst_n && tag_we)  tag_q[look_idx][victim_q] <= look_tag;
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic        accept;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign accept = (state_q == StIdle) && (i_req_ren || i_req_wen);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{look_addr[1:0], hit_vec};

endmodule

// File: tb/tb_assoc_cache.sv
// Randomised bench for assoc_cache against a behavioural cache/memory reference model.
module tb_assoc_cache;

  localparam int WAYS  = 2;
  localparam int SETS  = 32;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        busy;
  logic [31:0] req_addr = '0;
  logic        req_ren = 1'b0, req_wen = 1'b0;
  logic [3:0]  req_mask = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] res_rdata;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  assoc_cache #(
    .WAYS       (WAYS),
    .SETS_LOG2  (5),
    .WORDS_LOG2 (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mem_ready (mem_ready),
    .o_mem_addr  (mem_addr),
    .o_mem_ren   (mem_ren),
    .o_mem_wen   (mem_wen),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_valid (mem_valid),
    .o_busy      (busy),
    .i_req_addr  (req_addr),
    .i_req_ren   (req_ren),
    .i_req_wen   (req_wen),
    .i_req_mask  (req_mask),
    .i_req_wdata (req_wdata),
    .o_res_rdata (res_rdata)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory: words never written read back as a fixed hash of their address.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Reference cache state: which tags live in which ways, and the MRU way per set.
  bit          m_valid [SETS][WAYS];
  logic [22:0] m_tag   [SETS][WAYS];
  int          m_mru   [SETS];

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_mru[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  function automatic int model_find(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[a[8:4]][w] && m_tag[a[8:4]][w] == a[31:9]) return w;
    return -1;
  endfunction

  function automatic int model_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return (m_mru[s] + 1) % WAYS;
  endfunction

  // Memory responder state, driven from the single stimulus process.
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_dly;
  int          stall_left = 0;
  logic        s_busy, s_ren, s_wen, rd_fire, wr_fire;
  logic [31:0] s_addr, s_wdata, s_rdata;

  task automatic mem_cycle();
    mem_valid = 1'b0;
    mem_rdata = $urandom;
    if (pend) begin
      if (pend_dly == 0) begin
        mem_valid = 1'b1;
        mem_rdata = memrd(pend_addr);
        pend      = 1'b0;
      end else pend_dly--;
    end else if ($urandom_range(7) == 0) mem_valid = 1'b1;
    #1;
    s_busy  = busy;
    s_ren   = mem_ren;
    s_wen   = mem_wen;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    s_rdata = res_rdata;
    check_eq("ren_wen_excl", 32'(s_ren & s_wen), 32'd0);
    if (s_wen && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else mem_ready = ($urandom_range(3) != 0);
    rd_fire = s_ren & mem_ready;
    wr_fire = s_wen & mem_ready;
    if (rd_fire) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_dly  = $urandom_range(2);
    end
  endtask

  task automatic drop_req();
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop_req();
    mem_ready = 1'b0;
    #1;
    check_eq("rst_ren", 32'(mem_ren), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    pend = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
  endtask

  // One hart transaction: drive, act as memory until done, check traffic and result.
  task automatic access(input logic [31:0] addr, input bit wr, input logic [3:0] mask,
                        input logic [31:0] wdata, input bit both);
    int          way, rd_n, wr_n;
    bit          done;
    logic [31:0] base, merged;
    way    = model_find(addr);
    base   = {addr[31:4], 4'b0000};
    merged = merge(memrd(addr), wdata, mask);
    rd_n   = 0;
    wr_n   = 0;
    done   = 1'b0;
    @(negedge clk);
    req_addr  = addr;
    req_ren   = !wr || both;
    req_wen   = wr;
    req_mask  = mask;
    req_wdata = wdata;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_cycle();
      if (cyc == 0) check_eq("busy_first", 32'(s_busy), 32'(wr || way < 0));
      if (rd_fire) begin
        check_eq("fill_addr", s_addr, base + 32'(rd_n * 4));
        rd_n++;
      end
      if (s_wen) begin
        check_eq("busy_wr", 32'(s_busy), 32'd1);
        check_eq("wr_addr", s_addr, {addr[31:2], 2'b00});
        check_eq("wr_data", s_wdata, merged);
      end
      if (wr_fire) begin
        wr_n++;
        mem[addr >> 2] = merged;
        done = 1'b1;
      end
      if (!wr && !s_busy) begin
        check_eq("rdata", s_rdata, memrd(addr));
        check_eq("hit_no_ren", 32'(s_ren), 32'd0);
        done = 1'b1;
      end
    end
    check_eq("done", 32'(done), 32'd1);
    check_eq("fill_reads", 32'(rd_n), (way < 0) ? WORDS : 0);
    check_eq("mem_writes", 32'(wr_n), wr ? 32'd1 : 32'd0);
    if (way < 0) begin
      way = model_victim(addr[8:4]);
      m_valid[addr[8:4]][way] = 1'b1;
      m_tag[addr[8:4]][way]   = addr[31:9];
    end
    m_mru[addr[8:4]] = way;
    @(negedge clk);
    drop_req();
  endtask

  task automatic reset_mid_fill(input logic [31:0] addr);
    bit fired;
    fired = 1'b0;
    @(negedge clk);
    req_addr = addr;
    req_ren  = 1'b1;
    req_wen  = 1'b0;
    for (int c = 0; c < 100 && !fired; c++) begin
      if (c > 0) @(negedge clk);
      mem_cycle();
      fired = rd_fire;
    end
    check_eq("mid_fill_issued", 32'(fired), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    drop_req();
    mem_ready = 1'b0;
    #1;
    check_eq("mid_rst_ren", 32'(mem_ren), 32'd0);
    check_eq("mid_rst_wen", 32'(mem_wen), 32'd0);
    check_eq("mid_rst_addr", mem_addr, 32'd0);
    check_eq("mid_rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("late_valid_busy", 32'(busy), 32'd0);
    check_eq("late_valid_ren", 32'(mem_ren), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    check_eq("after_rst_ren", 32'(mem_ren), 32'd0);
    model_clear();
    pend = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    bit          wr;
    mem[32'h100 >> 2] = 32'h1122_3344;
    model_clear();
    do_reset();
    access(32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h104, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h100, 1'b1, 4'b0010, 32'hAABB_CCDD, 1'b0);
    access(32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h000, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h200, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h000, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h400, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h000, 1'b0, 4'h0, 32'h0, 1'b0);
    access(32'h200, 1'b0, 4'h0, 32'h0, 1'b0);
    stall_left = 3;
    access(32'h300, 1'b1, 4'b1001, 32'hCAFE_F00D, 1'b0);
    access(32'h30C, 1'b1, 4'b1111, 32'h0BAD_F00D, 1'b1);
    reset_mid_fill(32'h600);
    access(32'h000, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 250; i++) begin
      a  = (32'($urandom_range(3)) << 9) | (32'($urandom_range(1)) << 4)
         | (32'($urandom_range(3)) << 2) | 32'($urandom_range(3));
      wr = ($urandom_range(2) == 0);
      if (wr) stall_left = $urandom_range(3);
      access(a, wr, 4'($urandom_range(15)), $urandom, wr && ($urandom_range(7) == 0));
      stall_left = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2, ways per set (1, 2, 4 or 8).
REQ-002 SHALL have parameter SETS_LOG2, default 5, log2 of set count.
REQ-003 SHALL have parameter WORDS_LOG2, default 2, log2 of 32-bit words per line.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports i_mem_ready input 1, o_mem_addr output 32, o_mem_ren output 1, o_mem_wen output 1, o_mem_wdata output 32, i_mem_rdata input 32, i_mem_valid input 1: word-granular backing-memory interface.
REQ-007 SHALL have ports o_busy output 1, i_req_addr input 32, i_req_ren input 1, i_req_wen input 1, i_req_mask input 4, i_req_wdata input 32, o_res_rdata output 32: hart-side interface.

Function
REQ-008 SHALL split address as tag [31:SETS_LOG2+WORDS_LOG2+2], index [SETS_LOG2+WORDS_LOG2+1:WORDS_LOG2+2], word [WORDS_LOG2+1:2]; bits [1:0] ignored.
REQ-009 SHALL be write-through, write-allocate; memory accessed only at word granularity, byte masking merged internally.
REQ-010 SHALL implement FSM states IDLE, FILL_REQ, FILL_WAIT, WRITE; reset state IDLE.
REQ-011 Read hit in IDLE: o_res_rdata = hit word combinationally, o_busy=0, no memory traffic.
REQ-012 Read miss or any write in IDLE: o_busy=1 combinationally same cycle; request latched; hart holds address/mask/wdata while busy.
REQ-013 Miss SHALL go to FILL_REQ, filling words 0..2^WORDS_LOG2-1 in ascending order at {tag,index,k,2'b00}; one outstanding read.
REQ-014 FILL_REQ: o_mem_ren=1 until i_mem_ready=1, then FILL_WAIT; FILL_WAIT: on i_mem_valid store i_mem_rdata, next word or finish.
REQ-015 Fill finish: write tag, set valid, update MRU; read -> IDLE; write -> WRITE.
REQ-016 Write hit: on the edge leaving IDLE, cached word updated with mask-merged data; go to WRITE.
REQ-017 After write-allocate fill, same merge applied to filled line before WRITE.
REQ-018 WRITE: o_mem_wen=1, o_mem_wdata = full merged word, until i_mem_ready=1, then IDLE.
REQ-019 o_busy SHALL be 1 in every non-IDLE state; cycle after return to IDLE, held read address hits and o_res_rdata valid with o_busy=0.
REQ-020 Victim: lowest-index invalid way; else (MRU+1) mod WAYS; per-set MRU updated on every hit and fill (NMRU generalised; WAYS=1 direct-mapped).
REQ-021 i_req_ren and i_req_wen both high: illegal; SHALL treat as write.
REQ-022 i_mem_valid outside FILL_WAIT SHALL be ignored.
REQ-023 o_mem_ren and o_mem_wen SHALL never be high together; o_mem_addr word-aligned.

Reset
REQ-024 i_rst_n=0 at an edge SHALL force IDLE, clear all valid and MRU bits, fill counter 0; mid-fill or mid-write reset abandons operation.
REQ-025 During/after reset o_mem_ren=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0; o_busy follows REQ-012 only.
REQ-026 Data and tag arrays SHALL NOT be reset.

Configuration
REQ-027 Macro ASSOC_CACHE_STATS_EN defined: adds outputs o_hit_count, o_miss_count (32-bit, saturating at 0xFFFFFFFF), counting each accepted request once in IDLE, cleared by reset.
REQ-028 Macro undefined: no counter ports or logic; behaviour otherwise identical.

Structure
REQ-029 Package cache_pkg SHALL hold state_t enum and address-field width functions/constants.
REQ-030 Sub-module cache_way_match SHALL compare tag against WAYS tag/valid entries, outputting one-hot hit vector and hit-way index.

Verification
REQ-031 Reset, read 0x0000_0100 -> o_busy=1, 4 reads 0x100..0x10C, then o_res_rdata=mem[0x100], o_busy=0.
REQ-032 Repeat read 0x0000_0104 after fill -> hit same cycle, o_busy=0, no o_mem_ren.
REQ-033 Write 0xAABBCCDD mask 4'b0010 to cached 0x100 holding 0x11223344 -> o_mem_wen, o_mem_wdata=0x1122CC44, subsequent read returns it.
REQ-034 WAYS=2: fill 0x000, 0x200, read 0x000, then read 0x400 -> evicts 0x200 line; read 0x000 still hits.
REQ-035 Write miss 0x300 -> 4-word fill, then merged write; i_mem_ready low 3 cycles -> o_mem_wen held, o_busy=1 throughout.
REQ-036 i_rst_n low during FILL_WAIT -> IDLE next cycle, late i_mem_valid ignored, prior line misses again.
